// File: rtl/sqrt_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_pkg
// Shared definitions for the square-root request arbiter and related blocks.
//   - SQRT_N_W / SQRT_R_W : operand and root widths of the sqrt engine
//   - DEF_TIMEOUT_CYCLES  : default watchdog limit while waiting on the engine
//   - arb_state_e         : arbiter state encoding
// -----------------------------------------------------------------------------
package sqrt_pkg;

    localparam int SQRT_N_W           = 8;
    localparam int SQRT_R_W           = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/sqrt_req_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational circular priority select: returns the first set request bit
// at or after ptr, wrapping around to bit 0.
// Ports:
//   req   in  N      request vector
//   ptr   in  IDX_W  scan start position (0..N-1)
//   valid out 1      any request set
//   idx   out IDX_W  index of the selected request (0 when valid=0)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int j;

    // Walk the offsets from farthest to nearest so the candidate closest to
    // ptr is the one written last and therefore wins.
    always_comb begin
        valid = |req;
        idx   = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[IDX_W'(j)]) begin
                idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/sqrt_req_arbiter.sv
// -----------------------------------------------------------------------------
// sqrt_req_arbiter
// Round-robin scheduler sharing one external iterative 8-bit square-root
// engine among NUM_REQ requesters. A winner's operand is loaded into eng_n,
// the engine is driven through a level start/done handshake, and the root is
// returned to the winner together with a one-cycle ack.
//
// Optional feature macro: SQRT_ARB_TIMEOUT_EN
//   defined   : watchdog in WAIT_DONE; after TIMEOUT_CYCLES without eng_done
//               the winner is acked with res_err=1 and res_sqrt=0.
//   undefined : res_err tied to 0; a stuck engine holds the block in
//               WAIT_DONE until reset.
//
// Ports:
//   clk       in  1           rising-edge clock
//   rst       in  1           synchronous active-high reset
//   req       in  NUM_REQ     per-requester request level
//   req_n     in  8*NUM_REQ   operands, requester i on [8i+7:8i]
//   ack       out NUM_REQ     one-hot one-cycle result strobe
//   res_sqrt  out 4           root, valid with ack
//   res_err   out 1           timeout flag, valid with ack
//   busy      out 1           state is not IDLE
//   eng_st    out 1           engine start level
//   eng_n     out 8           engine operand (registered)
//   eng_done  in  1           engine done level
//   eng_sqrt  in  4           engine root, valid while eng_done=1
// -----------------------------------------------------------------------------
module sqrt_req_arbiter
    import sqrt_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [SQRT_N_W*NUM_REQ-1:0]  req_n,
    output logic [NUM_REQ-1:0]           ack,
    output logic [SQRT_R_W-1:0]          res_sqrt,
    output logic                         res_err,
    output logic                         busy,
    output logic                         eng_st,
    output logic [SQRT_N_W-1:0]          eng_n,
    input  logic                         eng_done,
    input  logic [SQRT_R_W-1:0]          eng_sqrt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      gnt_idx_q, gnt_idx_d;
    logic [SQRT_N_W-1:0]   eng_n_q, eng_n_d;
    logic                  eng_st_q, eng_st_d;
    logic [SQRT_R_W-1:0]   res_sqrt_q, res_sqrt_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic [IDX_W-1:0]      ptr_after_gnt;

    logic                  pick_valid;
    logic [IDX_W-1:0]      pick_idx;

    // Per-requester operand view of the flat req_n bus.
    logic [SQRT_N_W-1:0]   opnd [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_opnd
        assign opnd[gi] = req_n[gi*SQRT_N_W +: SQRT_N_W];
    end

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Pointer moves just past the winner so a requester that stays high
    // cannot win twice while others wait.
    assign ptr_after_gnt = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                              : gnt_idx_q + IDX_W'(1);

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             res_err_q, res_err_d;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_idx_d  = gnt_idx_q;
        eng_n_d    = eng_n_q;
        eng_st_d   = eng_st_q;
        res_sqrt_d = res_sqrt_q;
        ack_d      = '0;
`ifdef SQRT_ARB_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        res_err_d  = res_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_idx_d = pick_idx;
                    eng_n_d   = opnd[pick_idx];
                    state_d   = START;
                end
            end
            START: begin
                eng_st_d = 1'b1;
                state_d  = WAIT_DONE;
`ifdef SQRT_ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            WAIT_DONE: begin
                if (eng_done) begin
                    res_sqrt_d = eng_sqrt;
                    eng_st_d   = 1'b0;
                    state_d    = RELEASE;
                end
`ifdef SQRT_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    // Abandon the engine: report an error result directly,
                    // there is no done level to wait out.
                    eng_st_d          = 1'b0;
                    res_sqrt_d        = '0;
                    res_err_d         = 1'b1;
                    ack_d[gnt_idx_q]  = 1'b1;
                    ptr_d             = ptr_after_gnt;
                    state_d           = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            RELEASE: begin
                // Hold off the ack until the engine is idle again so the next
                // START cannot see a stale done level.
                if (!eng_done) begin
                    ack_d[gnt_idx_q] = 1'b1;
                    ptr_d            = ptr_after_gnt;
                    state_d          = IDLE;
`ifdef SQRT_ARB_TIMEOUT_EN
                    res_err_d        = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_idx_q  <= '0;
            eng_n_q    <= '0;
            eng_st_q   <= 1'b0;
            res_sqrt_q <= '0;
            ack_q      <= '0;
`ifdef SQRT_ARB_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            res_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            eng_n_q    <= eng_n_d;
            eng_st_q   <= eng_st_d;
            res_sqrt_q <= res_sqrt_d;
            ack_q      <= ack_d;
`ifdef SQRT_ARB_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            res_err_q  <= res_err_d;
`endif
        end
    end

    assign ack      = ack_q;
    assign res_sqrt = res_sqrt_q;
    assign busy     = (state_q != IDLE);
    assign eng_st   = eng_st_q;
    assign eng_n    = eng_n_q;
`ifdef SQRT_ARB_TIMEOUT_EN
    assign res_err  = res_err_q;
`else
    assign res_err  = 1'b0;
`endif

endmodule

// File: doc/sqrt_req_arbiter.md
Name: sqrt_req_arbiter

Overview:
- Round-robin scheduler sharing one iterative 8-bit square-root engine among NUM_REQ requesters.
- Selects a requester, loads its operand, and drives the engine's level start/done handshake.
- Captures the 4-bit root and returns it to the winner with a one-cycle ack.
- Sits between client blocks and the odd-subtraction sqrt unit; the engine is external and connected through the eng_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT_DONE (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_n  in  8*NUM_REQ  operands, requester i on bits [8i+7:8i]; held stable while req[i]=1.
- ack  out  NUM_REQ  one-hot, one-cycle result strobe.
- res_sqrt  out  4  result, valid when any ack bit is set.
- res_err  out  1  timeout flag, qualified by ack.
- busy  out  1  high whenever state is not IDLE.
- eng_st  out  1  engine start level.
- eng_n  out  8  engine operand, registered.
- eng_done  in  1  engine done level.
- eng_sqrt  in  4  engine root, valid while eng_done=1.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE, round-robin pointer to 0.
  - ack, res_sqrt, res_err, eng_st, eng_n and busy all go to 0.
  - Integration ties the engine's active-low reset to ~rst, so a mid-operation reset clears both blocks in the same cycle.
- IDLE:
  - If any req bit is set, grant the first set bit at or after the pointer (circular scan).
  - On grant: latch its index into gnt_idx, latch req_n[gnt_idx] into eng_n, go to START.
- START:
  - eng_st <= 1; go to WAIT_DONE.
- WAIT_DONE:
  - eng_st stays 1.
  - When eng_done=1: capture eng_sqrt into res_sqrt, eng_st <= 0, go to RELEASE.
- RELEASE:
  - Wait for eng_done=0 (engine back in its idle state).
  - Then assert ack[gnt_idx]=1 for exactly one cycle with res_sqrt valid, set pointer <= (gnt_idx+1) mod NUM_REQ, go to IDLE.
- Requester side:
  - A requester must drop req the cycle after its ack.
  - A req still high in IDLE is a new request and competes normally; the pointer has moved past it, so it cannot starve others.
- Simultaneous requests: the lowest index at or after the pointer wins; the other requests stay pending and unacknowledged.
- Deasserting req before ack is a protocol violation. The grant proceeds anyway and the ack is still issued.
- The operand is sampled only in IDLE; later changes to req_n are ignored.
- Latency:
  - Grant to eng_st = 1 cycle.
  - ack = 1 cycle after eng_done falls.
  - Minimum service time = engine time + 4 cycles.
- res_sqrt holds its last value between acks. Only the ack-qualified value is defined.

Optional Feature:
- Macro: SQRT_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_DONE and increments each cycle there.
  - When it reaches TIMEOUT_CYCLES with eng_done still 0: eng_st <= 0, res_sqrt <= 0, res_err <= 1.
  - The winner's ack pulses the next cycle, the pointer advances, and the state returns to IDLE, skipping RELEASE.
  - res_err clears on the next ack or on reset.
- Undefined: no counter; res_err is tied to 0; a stuck engine hangs the block in WAIT_DONE until reset.

Decomposition:
- Shared package sqrt_pkg:
  - State encoding constants IDLE=0, START=1, WAIT_DONE=2, RELEASE=3.
  - SQRT_N_W=8, SQRT_R_W=4.
  - Default TIMEOUT_CYCLES.
- One natural sub-module, rr_pick: combinational circular priority select.
  - Inputs: req, pointer.
  - Outputs: valid, index.
  - Reusable by other shared-resource arbiters.

Test Plan:
- Single request: req[0]=1, N=144 -> eng_n=144, one ack[0] pulse, res_sqrt=12, res_err=0; also N=0 -> 0 and N=255 -> 15.
- Simultaneous requests: req[2:0] all set with N=16, 81, 200 and pointer 0 -> acks in order 0, 1, 2 with roots 4, 9, 14; busy stays high between services.
- Fairness: req[0] held continuously, req[3] raised with N=49 -> after ack[0], the next ack is ack[3] with root 7, before any repeat of ack[0].
- Reset mid-operation: assert rst in WAIT_DONE -> next cycle eng_st=0, busy=0, ack=0, pointer=0; a fresh request then completes normally.
- Handshake order: a model engine holds eng_done high for 3 cycles -> ack fires exactly 1 cycle after eng_done falls, never earlier.
- Timeout (macro defined): model engine never asserts done -> after 64 cycles in WAIT_DONE, ack[i] pulses with res_err=1 and res_sqrt=0; the next request is serviced normally.
